// File: rtl/led_div_seq.sv
// led_div_seq: steps the led_cnt divider (div/wren pair) through a small
// programmable table, holding each entry for a programmable number of dwell
// ticks and wrapping at the end. A level request/acknowledge override lets
// another agent take over the divider for as long as it holds the request.
//
// Ports:
//   clk100       system clock (100 MHz)
//   rstn         asynchronous active-low reset
//   enable_i     run the sequence while high
//   tbl_we_i     table write strobe (one entry per cycle)
//   tbl_addr_i   table entry index for writes
//   tbl_div_i    divider value to store
//   tbl_dwell_i  dwell in ticks to store (0 behaves as 1)
//   ovr_req_i    override request (level)
//   ovr_div_i    override divider value, sampled on grant
//   ovr_ack_o    override granted
//   div_o        divider value to led_cnt
//   wren_o       one-cycle load strobe, coincident with a new div_o
//   step_o       current table index
//   busy_o       high whenever the sequencer is not idle
module led_div_seq #(
  parameter int unsigned NUM_STEPS   = 4,
  parameter int unsigned DIVW        = 5,
  parameter int unsigned DWELLW      = 16,
  parameter int unsigned TICK_CYCLES = 100000,
  localparam int unsigned IDXW       = $clog2(NUM_STEPS)
) (
  input  logic              clk100,
  input  logic              rstn,
  input  logic              enable_i,
  input  logic              tbl_we_i,
  input  logic [IDXW-1:0]   tbl_addr_i,
  input  logic [DIVW-1:0]   tbl_div_i,
  input  logic [DWELLW-1:0] tbl_dwell_i,
  input  logic              ovr_req_i,
  input  logic [DIVW-1:0]   ovr_div_i,
  output logic              ovr_ack_o,
  output logic [DIVW-1:0]   div_o,
  output logic              wren_o,
  output logic [IDXW-1:0]   step_o,
  output logic              busy_o
);

  localparam int unsigned PREW  = $clog2(TICK_CYCLES);
  // Table is sized to the full index range so any address is a legal write.
  localparam int unsigned DEPTH = 1 << IDXW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_OVR
  } state_e;

  state_e            state_q;
  logic [DIVW-1:0]   div_q;
  logic              wren_q;
  logic              ack_q;
  logic [IDXW-1:0]   step_q;
  logic [DWELLW-1:0] dwl_q;
  logic [PREW-1:0]   pre_q;
  logic [DIVW-1:0]   tbl_div_q   [DEPTH];
  logic [DWELLW-1:0] tbl_dwell_q [DEPTH];

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      wren_q  <= 1'b0;
      ack_q   <= 1'b0;
      step_q  <= '0;
      dwl_q   <= '0;
      pre_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_div_q[i]   <= '0;
        tbl_dwell_q[i] <= DWELLW'(1);
      end
    end else begin
      wren_q <= 1'b0;

      // LOAD below reads the pre-write contents when both hit the same entry.
      if (tbl_we_i) begin
        tbl_div_q[tbl_addr_i]   <= tbl_div_i;
        tbl_dwell_q[tbl_addr_i] <= tbl_dwell_i;
      end

      case (state_q)
        ST_IDLE: begin
          if (ovr_req_i) begin
            state_q <= ST_OVR;
            div_q   <= ovr_div_i;
            wren_q  <= 1'b1;
            ack_q   <= 1'b1;
          end else if (enable_i) begin
            state_q <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (!enable_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_DWELL;
            div_q   <= tbl_div_q[step_q];
            wren_q  <= 1'b1;
            dwl_q   <= (tbl_dwell_q[step_q] == '0) ? DWELLW'(1) : tbl_dwell_q[step_q];
            pre_q   <= '0;
          end
        end

        ST_DWELL: begin
          // Override beats both a disable and a simultaneous dwell expiry.
          if (ovr_req_i) begin
            state_q <= ST_OVR;
            div_q   <= ovr_div_i;
            wren_q  <= 1'b1;
            ack_q   <= 1'b1;
          end else if (!enable_i) begin
            state_q <= ST_IDLE;
          end else if (pre_q == PREW'(TICK_CYCLES - 1)) begin
            pre_q <= '0;
            // dwl_q is never loaded below 1, so expiry is its last tick.
            if (dwl_q == DWELLW'(1)) begin
              state_q <= ST_LOAD;
              step_q  <= (step_q == IDXW'(NUM_STEPS - 1)) ? '0 : step_q + IDXW'(1);
            end else begin
              dwl_q <= dwl_q - DWELLW'(1);
            end
          end else begin
            pre_q <= pre_q + PREW'(1);
          end
        end

        ST_OVR: begin
          if (!ovr_req_i) begin
            ack_q   <= 1'b0;
            state_q <= enable_i ? ST_LOAD : ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign div_o     = div_q;
  assign wren_o    = wren_q;
  assign ovr_ack_o = ack_q;
  assign step_o    = step_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule
